// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division, one bit per cycle.
// Results pass through a sign-fix cycle before HI/LO are written.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned AW = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             sgn_a, sgn_b, div_zero;
   logic [WIDTH-1:0] abs_a, abs_b;
   logic [WIDTH:0]   mul_sum;
   logic [AW-1:0]    mul_next;
   logic [WIDTH:0]   div_src, div_trial;
   logic             div_qbit;
   logic [WIDTH-1:0] div_rem;
   logic [AW-1:0]    div_next;
   logic [AW-1:0]    prod_fix;
   logic [WIDTH-1:0] quot_fix, rem_fix;

   // Operand conditioning: magnitudes for signed ops, raw values otherwise
   always_comb begin
      sgn_a    = ~op[0] & rs_data[WIDTH-1];
      sgn_b    = ~op[0] & rt_data[WIDTH-1];
      abs_a    = sgn_a ? (~rs_data + WIDTH'(1)) : rs_data;
      abs_b    = sgn_b ? (~rt_data + WIDTH'(1)) : rt_data;
      div_zero = (rt_data == '0);
   end

   // One shift-add multiply step and one restoring divide step on the accumulator
   always_comb begin
      mul_sum   = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_src   = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_src - {1'b0, opa_q};
      div_qbit  = ~div_trial[WIDTH];
      div_rem   = div_qbit ? div_trial[WIDTH-1:0] : div_src[WIDTH-1:0];
      div_next  = {div_rem, acc_q[WIDTH-2:0], div_qbit};
   end

   // Two's-complement sign fix of the finished magnitudes
   always_comb begin
      prod_fix = neg_res_q ? (~acc_q + AW'(1)) : acc_q;
      quot_fix = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
      rem_fix  = neg_rem_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];
   end

   // Next-state and register update logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      opa_d     = opa_q;
      acc_d     = acc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (flush) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (op[2] == 1'b0) begin
                     state_d  = S_RUN;
                     busy_d   = 1'b1;
                     cnt_d    = '0;
                     is_div_d = op[1];
                     if (!op[1]) begin
                        opa_d     = abs_a;
                        acc_d     = {{WIDTH{1'b0}}, abs_b};
                        neg_res_d = sgn_a ^ sgn_b;
                        neg_rem_d = 1'b0;
                     end else if (div_zero) begin
                        // Dividing the raw dividend by zero leaves rem=dividend, quot=all ones
                        opa_d     = '0;
                        acc_d     = {{WIDTH{1'b0}}, rs_data};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                     end else begin
                        opa_d     = abs_b;
                        acc_d     = {{WIDTH{1'b0}}, abs_a};
                        neg_res_d = sgn_a ^ sgn_b;
                        neg_rem_d = sgn_a;
                     end
                  end else if (op == OP_MTHI) begin
                     hi_d = rs_data;
                  end else if (op == OP_MTLO) begin
                     lo_d = rs_data;
                  end
               end
            end
            S_RUN: begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = S_FIX;
               end
            end
            S_FIX: begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  hi_d = prod_fix[AW-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opa_q     <= '0;
         acc_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         opa_q     <= opa_d;
         acc_q     <= acc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: arithmetic reference model checked every cycle,
// plus literal expectations on the directed vectors.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // reference model state
   logic [31:0] m_hi, m_lo;
   logic        m_busy, m_done;
   logic [63:0] m_res;
   int          m_left;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi,lo} of an iterative op, from plain arithmetic
   function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sp;
      int     sa, sb, q, r;
      logic [63:0] up;
      sa = int'(a);
      sb = int'(b);
      case (o)
         3'd0: begin
            sp = longint'(sa) * longint'(sb);
            return 64'(sp);
         end
         3'd1: begin
            up = {32'd0, a} * {32'd0, b};
            return up;
         end
         3'd2: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Cycle-level expectation: ops take 33 cycles, flush/rst cancel, MTHI/MTLO immediate
   always @(posedge clk) begin
      if (rst) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_busy = 1'b0;
            m_left = 0;
         end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               {m_hi, m_lo} = m_res;
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end else if (start) begin
            if (op <= 3'd3) begin
               m_res  = ref_result(op, rs_data, rt_data);
               m_busy = 1'b1;
               m_left = 33;
            end else if (op == 3'd4) begin
               m_hi = rs_data;
            end else if (op == 3'd5) begin
               m_lo = rs_data;
            end
         end
      end
   end

   // Compare DUT against the model on every falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 64'(busy), 64'(m_busy));
         chk("done", 64'(done), 64'(m_done));
         chk("hi",   64'(hi),   64'(m_hi));
         chk("lo",   64'(lo),   64'(m_lo));
      end
   end

   // Called at a falling edge: present one start for one cycle, then scramble operands
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom_range(0, 7)); rs_data = $urandom; rt_data = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat;
      issue(o, a, b);
      chk({name, "_busy"}, 64'(busy), 64'd1);
      wait_done(lat);
      chk({name, "_latency"}, 64'(lat), 64'd33);
      chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
      chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
   endtask

   logic [2:0]  t_op [4] = '{3'd0, 3'd2, 3'd2, 3'd3};
   logic [31:0] t_a  [4] = '{32'h7FFF_FFFF, 32'd7, 32'hFFFF_FFF8, 32'd100};
   logic [31:0] t_b  [4] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd7};
   logic [63:0] t_exp[4] = '{64'hC000_0000_8000_0000, {32'd1, 32'hFFFF_FFFD},
                             {32'hFFFF_FFFE, 32'd2}, {32'd2, 32'd14}};

   initial begin
      int lat;
      rst = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0; flush = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_hi",   64'(hi),   64'd0);
      chk("reset_lo",   64'(lo),   64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_zero", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      // issued on the done cycle: back-to-back acceptance
      run_op("b2b_divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

      for (int i = 0; i < 4; i++) begin
         chk("model_pin", ref_result(t_op[i], t_a[i], t_b[i]), t_exp[i]);
         run_op("table", t_op[i], t_a[i], t_b[i], t_exp[i][63:32], t_exp[i][31:0]);
      end

      issue(3'd4, 32'h1234_5678, 32'd0);
      chk("mthi_hi", 64'(hi), 64'h1234_5678);
      chk("mthi_busy", 64'(busy), 64'd0);
      issue(3'd5, 32'h9ABC_DEF0, 32'd0);
      chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
      chk("mtlo_done", 64'(done), 64'd0);
      issue(3'd6, 32'hFFFF_FFFF, 32'd0);
      chk("noop_busy", 64'(busy), 64'd0);

      // flush mid-op, with a start while busy that must be ignored
      issue(3'd0, 32'd3, 32'd4);
      issue(3'd4, 32'h0000_DEAD, 32'd0);
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      chk("flush_hi", 64'(hi), 64'h1234_5678);
      chk("flush_lo", 64'(lo), 64'h9ABC_DEF0);

      // flush coinciding with the result-write cycle
      issue(3'd1, 32'd5, 32'd5);
      repeat (32) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fixflush_done", 64'(done), 64'd0);
      chk("fixflush_lo", 64'(lo), 64'h9ABC_DEF0);

      // reset mid-op
      issue(3'd0, 32'd3, 32'd4);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clk);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);

      run_op("mult_small", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12);
      @(negedge clk);
      chk("done_pulse", 64'(done), 64'd0);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
